// File: rtl/beam_rbg_power_if.sv
// Beam power stream: 16-beam I/Q input with RBG sidebands, serialized per-beam power out.
interface beam_rbg_power_if #(
  parameter int BEAM = 16,
  parameter int OW   = 48,
  parameter int AW   = 41,
  parameter int BW   = $clog2(BEAM)
);
  logic                      i_tvalid;
  logic                      i_sop;
  logic                      i_eop;
  logic [BEAM-1:0][OW-1:0]   i_data_i;
  logic [BEAM-1:0][OW-1:0]   i_data_q;
  logic [7:0]                i_rbg_num;
  logic                      i_rbg_load;
  logic                      i_symb_clr;
  logic                      i_symb_1st;
  logic                      i_ready;
  logic                      o_valid;
  logic [BW-1:0]             o_beam;
  logic [AW-1:0]             o_pwr;
  logic [7:0]                o_rbg_num;
  logic [7:0]                o_re_cnt;
  logic                      o_symb_1st;
  logic                      o_last;
  logic                      o_ovf;

  modport slave (
    input  i_tvalid, i_sop, i_eop, i_data_i, i_data_q, i_rbg_num,
           i_rbg_load, i_symb_clr, i_symb_1st, i_ready,
    output o_valid, o_beam, o_pwr, o_rbg_num, o_re_cnt, o_symb_1st, o_last, o_ovf
  );

  modport master (
    output i_tvalid, i_sop, i_eop, i_data_i, i_data_q, i_rbg_num,
           i_rbg_load, i_symb_clr, i_symb_1st, i_ready,
    input  o_valid, o_beam, o_pwr, o_rbg_num, o_re_cnt, o_symb_1st, o_last, o_ovf
  );
endinterface

// File: rtl/beam_rbg_power.sv
// Per-beam RBG power accumulator: shift/saturate, square, sum, accumulate per window,
// then serialize one beam per beat over valid/ready.
module beam_rbg_lane #(
  parameter int OW = 48,
  parameter int DS = 16,
  parameter int SW = 16,
  parameter int AW = 41
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic signed [OW-1:0] di_i,
  input  logic signed [OW-1:0] dq_i,
  input  logic                 vld_i,
  input  logic                 restart_i,
  input  logic                 close_i,
  input  logic                 load_i,
  output logic [AW-1:0]        snap_o
);
  localparam int PW = 2*SW+1;
  localparam logic signed [OW-1:0] SMAX = OW'(2**(SW-1)-1);
  localparam logic signed [OW-1:0] SMIN = ~SMAX;

  logic signed [SW-1:0]   si_q, sq_q;
  logic        [2*SW-1:0] ii_q, qq_q;
  logic        [PW-1:0]   p_q;
  logic        [AW-1:0]   acc_q, acc_d, pend_q, snap_q;
  logic        [AW:0]     sum;
  logic signed [2*SW-1:0] ii_s, qq_s;

  function automatic logic signed [SW-1:0] sat(input logic signed [OW-1:0] x);
    logic signed [OW-1:0] sh;
    sh = x >>> DS;
    if (sh > SMAX)      return SMAX[SW-1:0];
    else if (sh < SMIN) return SMIN[SW-1:0];
    else                return sh[SW-1:0];
  endfunction

  assign ii_s = si_q * si_q;
  assign qq_s = sq_q * sq_q;

  // The window restart takes this RE's power alone; otherwise add with saturation.
  always_comb begin
    sum   = {1'b0, acc_q} + (AW+1)'(p_q);
    acc_d = restart_i ? AW'(p_q) : (sum[AW] ? '1 : sum[AW-1:0]);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      si_q   <= '0;
      sq_q   <= '0;
      ii_q   <= '0;
      qq_q   <= '0;
      p_q    <= '0;
      acc_q  <= '0;
      pend_q <= '0;
      snap_q <= '0;
    end else begin
      si_q <= sat(di_i);
      sq_q <= sat(dq_i);
      ii_q <= ii_s;
      qq_q <= qq_s;
      p_q  <= PW'(ii_q) + PW'(qq_q);
      if (vld_i) begin
        if (close_i) begin
          pend_q <= acc_d;
          acc_q  <= '0;
        end else begin
          acc_q  <= acc_d;
        end
      end
      if (load_i) snap_q <= pend_q;
    end
  end

  assign snap_o = snap_q;
endmodule

module beam_rbg_power #(
  parameter int BEAM = 16,
  parameter int OW   = 48,
  parameter int DS   = 16,
  parameter int SW   = 16,
  parameter int AW   = 41,
  parameter int BW   = $clog2(BEAM)
) (
  input logic i_clk,
  input logic i_reset,
  beam_rbg_power_if.slave bus
);
  localparam int LAT = 3;

  typedef struct packed {
    logic       sop;
    logic       eop;
    logic       load;
    logic       clr;
    logic       s1st;
    logic [7:0] rbg;
  } sb_t;

  typedef enum logic {IDLE, SEND} state_t;

  logic [LAT-1:0]          vld_pipe;
  sb_t  [LAT-1:0]          sb_pipe;
  sb_t                     sb_in, sb3;
  logic                    v3, restart, close;
  logic [7:0]              re_cnt_q, cnt_d;
  logic                    pend_vld_q, pend_1st_q, snap_1st_q;
  logic [7:0]              pend_cnt_q, pend_rbg_q, snap_cnt_q, snap_rbg_q;
  state_t                  state_q, state_d;
  logic [BW-1:0]           beam_q, beam_d;
  logic                    ovf_q, ovf_d, beat, last_beat, accept;
  logic [BEAM-1:0][AW-1:0] snap;

  assign sb_in   = {bus.i_sop, bus.i_eop, bus.i_rbg_load, bus.i_symb_clr,
                    bus.i_symb_1st, bus.i_rbg_num};
  assign v3      = vld_pipe[LAT-1];
  assign sb3     = sb_pipe[LAT-1];
  assign restart = sb3.sop | sb3.clr;
  assign close   = v3 & (sb3.load | sb3.eop);
  assign cnt_d   = restart ? 8'd1 : ((re_cnt_q == 8'hFF) ? 8'hFF : re_cnt_q + 8'd1);

  for (genvar b = 0; b < BEAM; b++) begin : g_lane
    beam_rbg_lane #(.OW(OW), .DS(DS), .SW(SW), .AW(AW)) u_lane (
      .clk_i     (i_clk),
      .rst_i     (i_reset),
      .di_i      (bus.i_data_i[b]),
      .dq_i      (bus.i_data_q[b]),
      .vld_i     (v3),
      .restart_i (restart),
      .close_i   (close),
      .load_i    (accept),
      .snap_o    (snap[b])
    );
  end

  // A pending snapshot lives one cycle; it is taken only if the serializer is free by then.
  assign beat      = (state_q == SEND) && bus.i_ready;
  assign last_beat = beat && (beam_q == BW'(BEAM-1));
  assign accept    = pend_vld_q && ((state_q == IDLE) || last_beat);

  always_comb begin
    state_d = state_q;
    beam_d  = beam_q;
    ovf_d   = pend_vld_q && !accept;
    case (state_q)
      IDLE: if (accept) begin
        state_d = SEND;
        beam_d  = '0;
      end
      SEND: if (beat) begin
        beam_d = beam_q + BW'(1);
        if (last_beat) begin
          if (accept) beam_d = '0;
          else        state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      vld_pipe   <= '0;
      sb_pipe    <= '0;
      re_cnt_q   <= '0;
      pend_vld_q <= 1'b0;
      pend_cnt_q <= '0;
      pend_rbg_q <= '0;
      pend_1st_q <= 1'b0;
      snap_cnt_q <= '0;
      snap_rbg_q <= '0;
      snap_1st_q <= 1'b0;
      state_q    <= IDLE;
      beam_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      vld_pipe   <= {vld_pipe[LAT-2:0], bus.i_tvalid};
      sb_pipe    <= {sb_pipe[LAT-2:0], sb_in};
      pend_vld_q <= close;
      if (v3) begin
        if (close) begin
          re_cnt_q   <= '0;
          pend_cnt_q <= cnt_d;
          pend_rbg_q <= sb3.rbg;
          pend_1st_q <= sb3.s1st;
        end else begin
          re_cnt_q   <= cnt_d;
        end
      end
      if (accept) begin
        snap_cnt_q <= pend_cnt_q;
        snap_rbg_q <= pend_rbg_q;
        snap_1st_q <= pend_1st_q;
      end
      state_q <= state_d;
      beam_q  <= beam_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.o_valid    = (state_q == SEND);
  assign bus.o_beam     = beam_q;
  assign bus.o_pwr      = snap[beam_q];
  assign bus.o_rbg_num  = snap_rbg_q;
  assign bus.o_re_cnt   = snap_cnt_q;
  assign bus.o_symb_1st = snap_1st_q;
  assign bus.o_last     = (state_q == SEND) && (beam_q == BW'(BEAM-1));
  assign bus.o_ovf      = ovf_q;
endmodule

// File: doc/beam_rbg_power.md
# beam_rbg_power

Per-beam RBG power accumulator at the output of the beam MAC stage. It consumes the 16-beam I/Q stream together with its sop/eop/tvalid and rbg_load/rbg_num/symb_clr/symb_1st sidebands, and sums |I|²+|Q|² per beam over each RBG window. At every window close it snapshots the sums and serializes them, one beam per beat, to the beam-selection logic over a valid/ready handshake.

## Interface
- BEAM, 16, beams per RE.
- OW, 48, input I/Q width, signed.
- DS, 16, arithmetic right shift applied to each input sample before squaring.
- SW, 16, sample width after shift and saturation, signed.
- AW, 41, accumulator/output power width, unsigned. Equals 2*SW+9.
- BW, $clog2(BEAM), beam index width.

- i_clk  in  1  clock; the only clock.
- i_reset  in  1  synchronous, active-high reset.
- i_tvalid  in  1  RE valid.
- i_sop / i_eop  in  1  first / last RE of the symbol stream.
- i_data_i / i_data_q  in  [BEAM-1:0][OW-1:0]  beam I/Q, signed.
- i_rbg_num  in  8  RBG index of the current RE.
- i_rbg_load  in  1  high on the last valid RE of an RBG.
- i_symb_clr  in  1  clear window, qualified by tvalid.
- i_symb_1st  in  1  first-symbol tag.
- i_ready  in  1  downstream accepts a beat.
- o_valid  out  1  power beat valid.
- o_beam  out  BW  beam index of the beat.
- o_pwr  out  AW  accumulated power.
- o_rbg_num  out  8  RBG of the snapshot.
- o_re_cnt  out  8  valid REs in the window, saturating at 255.
- o_symb_1st  out  1  symb_1st of the closing RE.
- o_last  out  1  beat with beam BEAM-1.
- o_ovf  out  1  one-cycle pulse when a snapshot is dropped.

## Operation
- Pipeline for all BEAM lanes in parallel:
  - S1: s = i_data >>> DS, saturated to [-2^(SW-1), 2^(SW-1)-1].
  - S2: squares of I and Q registered.
  - S3: p = I² + Q², 2*SW+1 bits, unsigned.
  - S4: accumulate.
- Sidebands (tvalid, sop, eop, rbg_load, rbg_num, symb_clr, symb_1st) are delayed to stay aligned with S4.
- S4, for each valid RE:
  - If sop or symb_clr: acc = p and re_cnt = 1, so the window restarts and includes this RE.
  - Otherwise: acc = acc + p, saturating at 2^AW-1, and re_cnt is incremented.
  - Invalid cycles leave the accumulators unchanged; sidebands on invalid cycles are ignored.
- Window close occurs on a valid RE carrying rbg_load or eop. The total including that RE goes to the snapshot together with rbg_num, re_cnt and symb_1st. The accumulators and re_cnt are then zeroed.
- Serializer FSM:
  - IDLE → SEND on snapshot accept; the beam counter is set to 0.
  - In SEND, o_valid=1. A beat completes on o_valid & i_ready, and the beam counter increments.
  - A completed beat at beam BEAM-1 (o_last=1) returns to IDLE, or stays in SEND with counter 0 if a new snapshot is accepted in the same cycle.
  - While i_ready=0, all outputs hold stable.
- Snapshot accept rule: accepted when the FSM is in IDLE, or when the last beat completes in the same cycle. Otherwise the snapshot is dropped, o_ovf pulses for 1 cycle, and the in-flight serialization is untouched.
- Reset: clears the pipeline, accumulators, re_cnt, snapshot and FSM (→ IDLE). All outputs are 0. A reset during SEND abandons the remaining beats.

## Timing
- Input cycle T with close → snapshot loaded at the end of T+4 → first beat (beam 0) at T+5.
- With i_ready held high, beam k appears at T+5+k and o_last at T+5+BEAM-1.
- Back-to-back closes are lossless if windows are at least BEAM valid REs apart and i_ready is held high.
- o_ovf is asserted at T+5 for a dropped snapshot.
- The handshake is combinational on i_ready, with no registered skid.

## Test plan
- **Single RBG.** 12 valid REs, all beams I=Q=0x10000 (DS=16 → s=1), rbg_load on RE 12, rbg_num=3, i_ready=1 → 16 beats starting 5 cycles after rbg_load. Each beat: o_pwr=24, o_re_cnt=12, o_rbg_num=3; o_last on beam 15.
- **Saturation.** Input I=Q=+2^47-1 for 192 REs → s=32767. Each RE adds 2·32767² = 2147352578, giving o_pwr = 192 × that, below 2^41. A separate sample of -2^47 → s=-32768.
- **Backpressure.** i_ready toggled 1,0,0,1,… during SEND → each beam appears once, in order 0..15, stable while i_ready=0; o_ovf stays 0 when the next close comes after the last beat.
- **Overflow.** Second close 6 REs after the first, with i_ready=1 → o_ovf pulses once; the second snapshot is lost. A third close coinciding exactly with the last beat → accepted, and beam 0 follows the next cycle.
- **symb_clr / sop / eop.**
  - symb_clr on RE 5 of 12 (power 2 each) → o_pwr=16, o_re_cnt=8.
  - eop without rbg_load after 7 REs → window flushed with o_re_cnt=7.
- **Reset mid-SEND.** i_reset for 1 cycle at beam 6 → o_valid=0 the next cycle. A new RBG afterwards → sums start from 0.
